// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-lite SRAM slave with programmable wait states, ERROR response and MSB-aligned byte/halfword lanes
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hready,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [1:0]     k_q, k_d, size_q, size_d;
  logic           write_q, write_d;
  logic [31:0]    mem [MEM_DEPTH];
  logic           accept, illegal, last, we;
  logic [3:0]     be;
  logic [31:0]    wd, rd;
  assign accept  = i_hsel & i_hready & (i_htrans inside {2'b10, 2'b11});
  assign illegal = (|i_haddr[ADDR_WIDTH-1:IW+2]) | (i_hsize > 3'd2) |
                   (i_hsize == 3'd1 & i_haddr[0]) | (i_hsize == 3'd2 & |i_haddr[1:0]);
  assign last     = state_q == ACCESS & cnt_q == 4'd0;
  assign o_hready = state_q == IDLE | state_q == ERR2 | last;
  assign o_hresp  = state_q == ERR1 | state_q == ERR2;
  assign we       = last & write_q & ~i_hreset;
  assign rd       = mem[idx_q];
  // next state: count down waits, otherwise take the accept/idle decision whenever the bus sees hready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    k_d     = k_q;
    size_d  = size_q;
    write_d = write_q;
    if (state_q == ERR1) state_d = ERR2;
    else if (state_q == ACCESS && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    else begin
      state_d = !accept ? IDLE : illegal ? ERR1 : ACCESS;
      cnt_d   = (accept & ~illegal) ? 4'(WAIT_STATES) : 4'd0;
      if (accept) begin
        idx_d   = i_haddr[2 +: IW];
        k_d     = i_haddr[1:0];
        size_d  = i_hsize[1:0];
        write_d = i_hwrite;
      end
    end
  end
  // byte enables and lane replication so the MSB-aligned bus data lands on byte k
  always_comb begin
    be       = size_q == 2'd0 ? 4'b0001 << k_q : size_q == 2'd1 ? 4'b0011 << k_q : 4'b1111;
    wd       = size_q == 2'd0 ? {4{i_hwdata[31:24]}} : size_q == 2'd1 ? {2{i_hwdata[31:16]}} : i_hwdata;
    o_hrdata = (last & ~write_q) ?
               (size_q == 2'd0 ? {rd[{k_q, 3'b000} +: 8], 24'h0} :
                size_q == 2'd1 ? {rd[{k_q, 3'b000} +: 16], 16'h0} : rd) : '0;
  end
  // control registers
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      k_q     <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end
  // array write on the edge that completes an OKAY write data phase
  always_ff @(posedge i_hclk) begin
    for (int b = 0; b < 4; b++) if (we & be[b]) mem[idx_q][8*b +: 8] <= wd[8*b +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed AHB transfers against three wait-state configurations with a response scoreboard
module tb_ahb_sram_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1, hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2;
  int          sel = 0;
  logic        r0, r2, r3, e0, e2, e3;
  logic [31:0] d0, d2, d3;
  logic        hready_o, hresp_o;
  logic [31:0] hrdata_o;
  typedef struct {logic resp; logic [31:0] rdata; int waits;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, waits = 0, done_cyc = 0, t0 = 0;
  bit active = 1'b0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (.i_hclk(clk), .i_hreset(rst), .i_hsel(hsel && sel == 0), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata), .i_hready(r0),
    .o_hready(r0), .o_hresp(e0), .o_hrdata(d0));
  ahb_sram_slave #(.WAIT_STATES(2)) u2 (.i_hclk(clk), .i_hreset(rst), .i_hsel(hsel && sel == 1), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata), .i_hready(r2),
    .o_hready(r2), .o_hresp(e2), .o_hrdata(d2));
  ahb_sram_slave #(.WAIT_STATES(3)) u3 (.i_hclk(clk), .i_hreset(rst), .i_hsel(hsel && sel == 2), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata), .i_hready(r3),
    .o_hready(r3), .o_hresp(e3), .o_hrdata(d3));

  assign hready_o = sel == 0 ? r0 : sel == 1 ? r2 : r3;
  assign hresp_o  = sel == 0 ? e0 : sel == 1 ? e2 : e3;
  assign hrdata_o = sel == 0 ? d0 : sel == 1 ? d2 : d3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: pops one expectation per data phase and checks waits, response and read data
  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      q.delete();
    end else begin
      if (active) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL scoreboard_empty observed=data_phase expected=none");
          active = 1'b0;
        end else if (!hready_o) begin
          waits++;
          chk("wait_resp", 32'(hresp_o), 32'(q[0].resp));
          chk("wait_rdata", hrdata_o, 32'h0);
        end else begin
          chk("resp", 32'(hresp_o), 32'(q[0].resp));
          chk("rdata", hrdata_o, q[0].rdata);
          chk("waits", 32'(waits), 32'(q[0].waits));
          void'(q.pop_front());
          active = 1'b0;
          done_cyc = cyc + 1;
        end
      end
      if (hready_o && hsel && htrans[1]) begin
        active = 1'b1;
        waits = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                       input logic resp, input logic [31:0] rdat, input logic [1:0] tr = 2'b10);
    exp_t e;
    int n;
    hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr;
    e.resp = resp; e.rdata = rdat; e.waits = resp ? 1 : (sel == 0 ? 0 : sel == 1 ? 2 : 3);
    q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!hready_o && n < 64);
    if (!hready_o) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=hready_0 expected=hready_1");
    end
    @(posedge clk); #1;
    hwdata = w ? wd : 32'h0;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 64) begin @(posedge clk); n++; end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0 pending", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hready", 32'(hready_o), 32'h1);
    chk("reset_hresp", 32'(hresp_o), 32'h0);
    chk("reset_hrdata", hrdata_o, 32'h0);
    @(posedge clk); #1;
    // back-to-back write then read, zero wait states
    issue(32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 32'h0);
    issue(32'h10, 0, 3'd2, 32'h0, 0, 32'hDEADBEEF);
    idle(); drain();
    // byte/halfword lanes
    issue(32'h20, 1, 3'd2, 32'h11223344, 0, 32'h0);
    issue(32'h21, 1, 3'd0, 32'hA5000000, 0, 32'h0);
    issue(32'h20, 0, 3'd2, 32'h0, 0, 32'h1122A544);
    issue(32'h21, 0, 3'd0, 32'h0, 0, 32'hA5000000);
    issue(32'h22, 0, 3'd1, 32'h0, 0, 32'h11220000);
    idle(); drain();
    // illegal transfers leave memory untouched
    issue(32'h0, 1, 3'd2, 32'h5A5A1234, 0, 32'h0);
    issue(32'h400, 1, 3'd2, 32'hFFFFFFFF, 1, 32'h0);
    issue(32'h3, 0, 3'd1, 32'h0, 1, 32'h0);
    issue(32'h0, 1, 3'd3, 32'hFFFFFFFF, 1, 32'h0);
    issue(32'h0, 0, 3'd2, 32'h0, 0, 32'h5A5A1234);
    idle(); drain();
    // IDLE, BUSY and deselected NONSEQ are no-ops
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("idle_hready", 32'(hready_o), 32'h1);
    chk("idle_hresp", 32'(hresp_o), 32'h0);
    chk("idle_hrdata", hrdata_o, 32'h0);
    @(posedge clk); #1 htrans = 2'b01;
    @(negedge clk);
    chk("busy_hready", 32'(hready_o), 32'h1);
    chk("busy_hresp", 32'(hresp_o), 32'h0);
    chk("busy_hrdata", hrdata_o, 32'h0);
    @(posedge clk); #1 hsel = 1'b0; htrans = 2'b10;
    @(negedge clk);
    chk("nosel_hready", 32'(hready_o), 32'h1);
    chk("nosel_hresp", 32'(hresp_o), 32'h0);
    chk("nosel_hrdata", hrdata_o, 32'h0);
    @(posedge clk); #1 idle();
    @(posedge clk); #1;
    issue(32'h0, 0, 3'd2, 32'h0, 0, 32'h5A5A1234);
    idle(); drain();
    // two wait states: four-beat burst
    sel = 1;
    issue(32'h40, 1, 3'd2, 32'h1, 0, 32'h0);
    t0 = cyc;
    issue(32'h44, 1, 3'd2, 32'h2, 0, 32'h0, 2'b11);
    issue(32'h48, 1, 3'd2, 32'h3, 0, 32'h0, 2'b11);
    issue(32'h4C, 1, 3'd2, 32'h4, 0, 32'h0, 2'b11);
    idle(); drain();
    chk("burst_cycles", 32'(done_cyc - t0), 32'd12);
    issue(32'h40, 0, 3'd2, 32'h0, 0, 32'h1);
    issue(32'h44, 0, 3'd2, 32'h0, 0, 32'h2, 2'b11);
    issue(32'h48, 0, 3'd2, 32'h0, 0, 32'h3, 2'b11);
    issue(32'h4C, 0, 3'd2, 32'h0, 0, 32'h4, 2'b11);
    idle(); drain();
    // three wait states: reset during the second wait cycle discards the write
    sel = 2;
    issue(32'h8, 1, 3'd2, 32'h12345678, 0, 32'h0);
    idle(); drain();
    issue(32'h8, 1, 3'd2, 32'hCAFEF00D, 0, 32'h0);
    idle();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_hready", 32'(hready_o), 32'h1);
    chk("rst_mid_hresp", 32'(hresp_o), 32'h0);
    @(posedge clk); #1;
    issue(32'h8, 0, 3'd2, 32'h0, 0, 32'h12345678);
    idle(); drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
